// File: rtl/clk_exchange_1.sv
// rtl/clk_exchange_1.sv - glitch-free 2:1 clock mux with break-before-make handshake
module clk_exchange_1 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in_0,
  input  logic rst_n_0,
  input  logic clk_in_1,
  input  logic rst_n_1,
  input  logic sel,
  output logic clk_out
);

  logic                   req0;
  logic                   req1;
  logic [SYNC_STAGES-1:0] sync0;
  logic [SYNC_STAGES-1:0] sync1;
  logic                   en0;
  logic                   en1;

  // A leg may only ask for the output once the other leg has let go of it.
  assign req0 = ~sel & ~en1;
  assign req1 = sel & ~en0;

  // Leg 0 request synchronizer into the clk_in_0 domain.
  always_ff @(posedge clk_in_0 or negedge rst_n_0) begin
    if (!rst_n_0) sync0 <= '0;
    else          sync0 <= {sync0[SYNC_STAGES-2:0], req0};
  end

  // Leg 0 enable updates on the falling edge so it only moves while clk_in_0 is low.
  always_ff @(negedge clk_in_0 or negedge rst_n_0) begin
    if (!rst_n_0) en0 <= 1'b0;
    else          en0 <= sync0[SYNC_STAGES-1];
  end

  // Leg 1 request synchronizer into the clk_in_1 domain.
  always_ff @(posedge clk_in_1 or negedge rst_n_1) begin
    if (!rst_n_1) sync1 <= '0;
    else          sync1 <= {sync1[SYNC_STAGES-2:0], req1};
  end

  // Leg 1 enable updates on the falling edge so it only moves while clk_in_1 is low.
  always_ff @(negedge clk_in_1 or negedge rst_n_1) begin
    if (!rst_n_1) en1 <= 1'b0;
    else          en1 <= sync1[SYNC_STAGES-1];
  end

  // Output gating must stay as plain AND/OR cells so no hazard is introduced.
  (* dont_touch = "true" *) logic gate0;
  (* dont_touch = "true" *) logic gate1;
  (* dont_touch = "true" *) logic gate_or;

  assign gate0   = clk_in_0 & en0;
  assign gate1   = clk_in_1 & en1;
  assign gate_or = gate0 | gate1;
  assign clk_out = gate_or;

endmodule

// File: tb/tb_clk_exchange_1.sv
// tb/tb_clk_exchange_1.sv - directed bench for the glitch-free clock mux
`timescale 1ns/100ps
module tb_clk_exchange_1;

  logic clk_in_0;
  logic clk_in_1;
  logic rst_n_0;
  logic rst_n_1;
  logic sel;
  logic clk_out;

  int checks;
  int failures;
  int glitch_cnt;
  int overlap_cnt;
  real last_edge;
  logic have_edge;

  typedef struct {
    logic  apply;
    real   t_sel;
    logic  sel_val;
    real   t_from;
    real   t_to;
    int    src;
    string name;
  } row_t;

  row_t rows [6];

  clk_exchange_1 #(.SYNC_STAGES(2)) dut (
    .clk_in_0 (clk_in_0),
    .rst_n_0  (rst_n_0),
    .clk_in_1 (clk_in_1),
    .rst_n_1  (rst_n_1),
    .sel      (sel),
    .clk_out  (clk_out)
  );

  initial begin
    clk_in_0 = 1'b0;
    forever #5 clk_in_0 = ~clk_in_0;
  end

  initial begin
    clk_in_1 = 1'b0;
    forever #21 clk_in_1 = ~clk_in_1;
  end

  // Both enables high together would let both clocks through.
  always @(dut.en0, dut.en1) begin
    if (dut.en0 && dut.en1) overlap_cnt <= overlap_cnt + 1;
  end

  // Measure every clk_out high/low interval once out of reset.
  always @(clk_out) begin
    if ($realtime > 21.0) begin
      if (have_edge && rst_n_0 && rst_n_1 && ($realtime - last_edge) < 5.0)
        glitch_cnt <= glitch_cnt + 1;
      last_edge <= $realtime;
      have_edge <= 1'b1;
    end
  end

  // src: 0 = clk_out held low, 1 = follows clk_in_0, 2 = follows clk_in_1
  task automatic check_window(input real t_from, input real t_to, input int src, input string name);
    int   n;
    int   bad;
    real  bad_t;
    logic exp;
    logic bad_act;
    n = $rtoi(t_to - t_from) + 1;
    bad = 0;
    bad_t = 0.0;
    bad_act = 1'b0;
    for (int i = 0; i < n; i++) begin
      #(t_from + i - $realtime);
      exp = (src == 0) ? 1'b0 : (src == 1) ? clk_in_0 : clk_in_1;
      if (clk_out !== exp && bad == 0) begin
        bad = 1;
        bad_t = $realtime;
        bad_act = clk_out;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s: at t=%0.1f clk_out=%b, required source %0d", name, bad_t, bad_act, src);
    end
  endtask

  initial begin
    glitch_cnt = 0;
    overlap_cnt = 0;
    last_edge = 0.0;
    have_edge = 1'b0;
    checks = 0;
    failures = 0;

    rows[0] = '{1'b0, 0.0,   1'b0, 41.5,  499.5,  1, "clk0_after_reset"};
    rows[1] = '{1'b1, 500.0, 1'b1, 520.5, 587.5,  0, "break_0to1_low"};
    rows[2] = '{1'b0, 0.0,   1'b1, 588.5, 699.5,  2, "make_clk1"};
    rows[3] = '{1'b1, 700.0, 1'b0, 700.5, 797.5,  2, "clk1_full_until_break"};
    rows[4] = '{1'b0, 0.0,   1'b0, 798.5, 819.5,  0, "break_1to0_low"};
    rows[5] = '{1'b0, 0.0,   1'b0, 820.5, 1200.5, 1, "make_clk0"};

    sel = 1'b0;
    rst_n_0 = 1'b1;
    rst_n_1 = 1'b1;
    #1;
    rst_n_0 = 1'b0;
    rst_n_1 = 1'b0;
    check_window(1.5, 20.5, 0, "reset_low");
    #(21.0 - $realtime);
    rst_n_0 = 1'b1;
    rst_n_1 = 1'b1;

    for (int r = 0; r < 6; r++) begin
      if (rows[r].apply) begin
        #(rows[r].t_sel - $realtime);
        sel = rows[r].sel_val;
      end
      check_window(rows[r].t_from, rows[r].t_to, rows[r].src, rows[r].name);
    end

    // 3ns sel pulse that misses every clk_in_0 rising edge
    #(1201.0 - $realtime);
    sel = 1'b1;
    #3;
    sel = 1'b0;
    check_window(1204.5, 1300.5, 1, "short_pulse_ignored");

    // 3ns sel pulse straddling the 1305 edge: one clk_in_0 pulse is dropped
    #(1303.0 - $realtime);
    sel = 1'b1;
    #3;
    sel = 1'b0;
    check_window(1320.5, 1334.5, 0, "short_pulse_dropout");
    check_window(1335.5, 1399.5, 1, "short_pulse_recover");

    // Select clk_in_1, then pulse its reset during a high phase
    #(1400.0 - $realtime);
    sel = 1'b1;
    check_window(1400.5, 1419.5, 1, "clk0_until_break");
    check_window(1420.5, 1532.5, 0, "gap_before_clk1");
    check_window(1533.5, 1619.5, 2, "clk1_selected");
    #(1620.0 - $realtime);
    rst_n_1 = 1'b0;
    check_window(1620.5, 1629.5, 0, "rst1_forces_low");
    #(1630.0 - $realtime);
    rst_n_1 = 1'b1;
    check_window(1630.5, 1721.5, 0, "rst1_resync_low");
    check_window(1722.5, 1900.5, 2, "rst1_resume_clk1");

    checks++;
    if (glitch_cnt != 0) begin
      failures++;
      $display("FAIL pulse_width: short intervals=%0d, required 0", glitch_cnt);
    end
    checks++;
    if (overlap_cnt != 0) begin
      failures++;
      $display("FAIL enable_overlap: overlaps=%0d, required 0", overlap_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
